reg_file_dumper: RTL and testbench

//  Streams the contents of the 64x32 register-file memory out, word by word, over a

---
 rtl/reg_file_pkg.sv | 17 +
 rtl/reg_file_dumper.sv | 108 ++++++++++
 tb/tb_reg_file_dumper.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and dump FSM state type for the register-file dumper.
package reg_file_pkg;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 64;
   localparam int ADDR_W = $clog2(DEPTH);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      SUM,
      FLUSH
   } dump_state_t;

endpackage

// File: rtl/reg_file_dumper.sv
// Streams all DEPTH register-file words out over a valid/ready channel, one dump per start.
// Optional feature macro: CHECKSUM_EN appends a modulo-2^DATA_W sum of all words as a final beat.
module reg_file_dumper
   import reg_file_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last
);

   dump_state_t state;

`ifdef CHECKSUM_EN
   logic [DATA_W-1:0] sum;
`endif

   logic out_free;
   logic at_last;

   assign out_free = !out_valid || out_ready;
   assign at_last  = (rd_addr == LAST_ADDR);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_addr   <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
`ifdef CHECKSUM_EN
         sum       <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            // rd_addr rests at 0 while idle, so word 0 loads on the start edge itself.
            // The done guard keeps a start in the done cycle from re-arming the dump.
            IDLE: begin
               if (start && !done) begin
                  busy      <= 1'b1;
                  out_data  <= rd_data;
                  out_valid <= 1'b1;
                  rd_addr   <= rd_addr + ADDR_W'(1);
`ifdef CHECKSUM_EN
                  sum       <= rd_data;
`endif
                  state     <= RUN;
               end
            end

            RUN: begin
               if (out_free) begin
                  out_data  <= rd_data;
                  out_valid <= 1'b1;
`ifdef CHECKSUM_EN
                  sum       <= sum + rd_data;
`endif
                  if (at_last) begin
`ifdef CHECKSUM_EN
                     state    <= SUM;
`else
                     out_last <= 1'b1;
                     state    <= FLUSH;
`endif
                  end else begin
                     rd_addr <= rd_addr + ADDR_W'(1);
                  end
               end
            end

`ifdef CHECKSUM_EN
            SUM: begin
               if (out_free) begin
                  out_data  <= sum;
                  out_valid <= 1'b1;
                  out_last  <= 1'b1;
                  state     <= FLUSH;
               end
            end
`endif

            FLUSH: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  rd_addr   <= '0;
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_file_dumper.sv
// Directed bench for reg_file_dumper: streaming, stalls, restart, reset abort, optional checksum beat.
module tb_reg_file_dumper;
   import reg_file_pkg::*;

`ifdef CHECKSUM_EN
   localparam int EXP_BEATS = DEPTH + 1;
`else
   localparam int EXP_BEATS = DEPTH;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic              out_last;

   logic [DATA_W-1:0] mem [0:DEPTH-1];

   int errors = 0;
   int checks = 0;

   logic [DATA_W-1:0] beat_data [0:127];
   logic              beat_last [0:127];
   int                beat_cyc  [0:127];
   int                nbeat;
   int                ndone;
   int                done_cyc;
   int                stall_err;

   always #5 clk = ~clk;

   assign rd_data = mem[rd_addr];

   reg_file_dumper dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last)
   );

   // Drives start at cycle 0 and records every handshake; inputs change and outputs are read at negedge.
   task automatic collect(input int mode, input int restart_beat, input bit start_on_done,
                          input int stop_beat);
      bit          restarted = 0;
      bit          prev_stall = 0;
      logic [31:0] prev_data = '0;
      logic        prev_last = 1'b0;
      int          post = 0;
      nbeat = 0; ndone = 0; done_cyc = -1; stall_err = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (stop_beat >= 0 && nbeat == stop_beat) break;
         if (cyc == 0) start = 1'b1;
         if (restart_beat >= 0 && !restarted && nbeat == restart_beat) begin
            start = 1'b1;
            restarted = 1;
         end
         if (prev_stall && !(out_valid === 1'b1 && out_data === prev_data && out_last === prev_last))
            stall_err++;
         if (done === 1'b1) begin
            ndone++;
            done_cyc = cyc;
            if (start_on_done) start = 1'b1;
         end
         out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         prev_stall = (out_valid === 1'b1) && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
         if (out_valid === 1'b1 && out_ready && nbeat < 128) begin
            beat_data[nbeat] = out_data;
            beat_last[nbeat] = out_last;
            beat_cyc[nbeat]  = cyc;
            nbeat++;
         end
         if (done_cyc >= 0) post++;
         if (post > 4) break;
      end
      if (stop_beat < 0) start = 1'b0;
      out_ready = 1'b1;
   endtask

   function automatic int order_bad();
      int bad = 0;
      for (int i = 0; i < DEPTH; i++)
         if (beat_data[i] !== mem[i]) bad++;
      return bad;
   endfunction

   function automatic int last_count();
      int n = 0;
      for (int i = 0; i < nbeat; i++)
         if (beat_last[i] === 1'b1) n++;
      return n;
   endfunction

   task automatic test_reset();
      @(negedge clk);
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got=%b want=0", done); end
      checks++; if (rd_addr !== '0)     begin errors++; $display("FAIL reset_addr got=%0d want=0", rd_addr); end
      checks++; if (out_data !== '0)    begin errors++; $display("FAIL reset_data got=%h want=0", out_data); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
      checks++; if (out_last !== 1'b0)  begin errors++; $display("FAIL reset_last got=%b want=0", out_last); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      $display("reset: outputs cleared, released");
   endtask

   task automatic test_stream();
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i);
      collect(0, -1, 0, -1);
      checks++; if (nbeat !== EXP_BEATS) begin errors++; $display("FAIL stream_beats got=%0d want=%0d", nbeat, EXP_BEATS); end
      checks++; if (order_bad() !== 0) begin errors++; $display("FAIL stream_order bad_words=%0d want=0", order_bad()); end
      checks++; if (beat_cyc[0] !== 1) begin errors++; $display("FAIL stream_latency got_cycle=%0d want=1", beat_cyc[0]); end
      checks++; if (beat_cyc[EXP_BEATS-1] !== EXP_BEATS) begin errors++; $display("FAIL stream_contiguous last_cycle=%0d want=%0d", beat_cyc[EXP_BEATS-1], EXP_BEATS); end
      checks++; if (last_count() !== 1 || beat_last[EXP_BEATS-1] !== 1'b1) begin errors++; $display("FAIL stream_last count=%0d final=%b want=1,1", last_count(), beat_last[EXP_BEATS-1]); end
      checks++; if (ndone !== 1) begin errors++; $display("FAIL stream_done_count got=%0d want=1", ndone); end
      checks++; if (done_cyc !== beat_cyc[EXP_BEATS-1] + 1) begin errors++; $display("FAIL stream_done_cycle got=%0d want=%0d", done_cyc, beat_cyc[EXP_BEATS-1] + 1); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stream_busy_end got=%b want=0", busy); end
`ifdef CHECKSUM_EN
      checks++; if (beat_data[DEPTH] !== 32'd2016) begin errors++; $display("FAIL stream_sum got=%h want=%h", beat_data[DEPTH], 32'd2016); end
`endif
      $display("stream: beats=%0d done=%0d", nbeat, ndone);
   endtask

   task automatic test_checksum();
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      mem[0] = 32'd5;
      mem[1] = 32'd7;
      collect(0, -1, 0, -1);
      checks++; if (nbeat !== EXP_BEATS) begin errors++; $display("FAIL csum_beats got=%0d want=%0d", nbeat, EXP_BEATS); end
      checks++; if (order_bad() !== 0) begin errors++; $display("FAIL csum_words bad_words=%0d want=0", order_bad()); end
`ifdef CHECKSUM_EN
      checks++; if (beat_data[DEPTH] !== 32'd12 || beat_last[DEPTH] !== 1'b1) begin errors++; $display("FAIL csum_beat got=%h last=%b want=0000000c last=1", beat_data[DEPTH], beat_last[DEPTH]); end
`else
      checks++; if (beat_last[DEPTH-1] !== 1'b1) begin errors++; $display("FAIL csum_last got=%b want=1", beat_last[DEPTH-1]); end
`endif
      $display("checksum: beats=%0d final=%h", nbeat, beat_data[EXP_BEATS-1]);
   endtask

   task automatic test_stall();
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i);
      collect(1, -1, 0, -1);
      checks++; if (stall_err !== 0) begin errors++; $display("FAIL stall_hold violations=%0d want=0", stall_err); end
      checks++; if (nbeat !== EXP_BEATS) begin errors++; $display("FAIL stall_beats got=%0d want=%0d", nbeat, EXP_BEATS); end
      checks++; if (order_bad() !== 0) begin errors++; $display("FAIL stall_order bad_words=%0d want=0", order_bad()); end
      checks++; if (ndone !== 1) begin errors++; $display("FAIL stall_done got=%0d want=1", ndone); end
      $display("stall: beats=%0d hold_violations=%0d", nbeat, stall_err);
   endtask

   task automatic test_wrap();
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'hFFFF_FFFF;
      collect(0, -1, 0, -1);
      checks++; if (nbeat !== EXP_BEATS) begin errors++; $display("FAIL wrap_beats got=%0d want=%0d", nbeat, EXP_BEATS); end
      checks++; if (order_bad() !== 0) begin errors++; $display("FAIL wrap_words bad_words=%0d want=0", order_bad()); end
`ifdef CHECKSUM_EN
      checks++; if (beat_data[DEPTH] !== 32'hFFFF_FFC0) begin errors++; $display("FAIL wrap_sum got=%h want=ffffffc0", beat_data[DEPTH]); end
`endif
      $display("wrap: beats=%0d final=%h", nbeat, beat_data[EXP_BEATS-1]);
   endtask

   task automatic test_restart();
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i);
      collect(0, 10, 0, -1);
      checks++; if (nbeat !== EXP_BEATS) begin errors++; $display("FAIL restart_beats got=%0d want=%0d", nbeat, EXP_BEATS); end
      checks++; if (order_bad() !== 0) begin errors++; $display("FAIL restart_order bad_words=%0d want=0", order_bad()); end
      checks++; if (ndone !== 1) begin errors++; $display("FAIL restart_done got=%0d want=1", ndone); end
      $display("restart: beats=%0d done=%0d", nbeat, ndone);
   endtask

   task automatic test_back_to_back();
      collect(0, -1, 1, -1);
      checks++; if (nbeat !== EXP_BEATS) begin errors++; $display("FAIL b2b_beats got=%0d want=%0d", nbeat, EXP_BEATS); end
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle busy=%b valid=%b want=0,0", busy, out_valid); end
      $display("back_to_back: beats=%0d busy=%b", nbeat, busy);
   endtask

   task automatic test_reset_mid();
      int bad = 0;
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i);
      collect(0, -1, 0, 20);
      reset = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_drop valid=%b busy=%b want=0,0", out_valid, busy); end
      checks++; if (rd_addr !== '0 || out_last !== 1'b0) begin errors++; $display("FAIL abort_clear addr=%0d last=%b want=0,0", rd_addr, out_last); end
      @(negedge clk);
      reset = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (done !== 1'b0 || out_valid !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL abort_quiet bad_cycles=%0d want=0", bad); end
      collect(0, -1, 0, -1);
      checks++; if (nbeat !== EXP_BEATS || beat_data[0] !== 32'd0) begin errors++; $display("FAIL abort_redump beats=%0d first=%h want=%0d,0", nbeat, beat_data[0], EXP_BEATS); end
      checks++; if (ndone !== 1) begin errors++; $display("FAIL abort_redump_done got=%0d want=1", ndone); end
      $display("reset_mid: redump beats=%0d done=%0d", nbeat, ndone);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      test_reset();
      test_stream();
      test_checksum();
      test_stall();
      test_wrap();
      test_restart();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
